// File: rtl/operand_collector_pkg.sv
// operand_collector_pkg: shared compute-unit types for the dispatcher/operand collector/EU path
package operand_collector_pkg;
  localparam int TagW = 3;
  localparam int PcW = 32;
  localparam int WarpW = 32;
  localparam int RegIdxW = 6;
  localparam int RegW = 32;
  typedef logic [TagW-1:0] tag_t;
  typedef logic [PcW-1:0] pc_t;
  typedef logic [WarpW-1:0] act_mask_t;
  typedef logic [RegIdxW-1:0] reg_idx_t;
  typedef logic [WarpW*RegW-1:0] operand_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, ISSUE} opc_state_e;
endpackage

// File: rtl/operand_collector.sv
// operand_collector: single-entry collector reading source operands over one RF port, then issuing to the EUs
// OPC_ISSUE_BYPASS_EN lets a new dispatch be accepted in the EU handshake cycle.
module operand_collector
  import operand_collector_pkg::*;
#(
  parameter int NumTags = 8,
  parameter int PcWidth = 32,
  parameter int WarpWidth = 32,
  parameter int RegIdxWidth = 6,
  parameter int OperandsPerInst = 2,
  parameter int RegWidth = 32,
  localparam int TagWidth = $clog2(NumTags),
  localparam int DataWidth = WarpWidth * RegWidth
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic opc_ready_o,
  input  logic disp_valid_i,
  input  logic [TagWidth-1:0] disp_tag_i,
  input  logic [PcWidth-1:0] disp_pc_i,
  input  logic [WarpWidth-1:0] disp_act_mask_i,
  input  logic [RegIdxWidth-1:0] disp_dst_i,
  input  logic [OperandsPerInst*RegIdxWidth-1:0] disp_operands_i,
  output logic rf_req_valid_o,
  input  logic rf_req_ready_i,
  output logic [RegIdxWidth-1:0] rf_req_idx_o,
  input  logic rf_rsp_valid_i,
  input  logic [DataWidth-1:0] rf_rsp_data_i,
  output logic eu_valid_o,
  input  logic eu_ready_i,
  output logic [TagWidth-1:0] eu_tag_o,
  output logic [PcWidth-1:0] eu_pc_o,
  output logic [WarpWidth-1:0] eu_act_mask_o,
  output logic [RegIdxWidth-1:0] eu_dst_o,
  output logic [OperandsPerInst*DataWidth-1:0] eu_operands_o
);
  localparam int KW = OperandsPerInst > 1 ? $clog2(OperandsPerInst) : 1;
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ = REQ;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_ISSUE = ISSUE;
  logic [1:0] state_q;
  logic [KW-1:0] k_q;
  logic [OperandsPerInst-1:0][RegIdxWidth-1:0] srcs_q;
  logic [OperandsPerInst-1:0][DataWidth-1:0] data_q;
  logic accept, last;
`ifdef OPC_ISSUE_BYPASS_EN
  assign opc_ready_o = state_q == S_IDLE || (state_q == S_ISSUE && eu_ready_i);
`else
  assign opc_ready_o = state_q == S_IDLE;
`endif
  assign accept = disp_valid_i && opc_ready_o;
  assign last = k_q == KW'(OperandsPerInst - 1);
  assign rf_req_valid_o = state_q == S_REQ;
  assign eu_valid_o = state_q == S_ISSUE;
  assign eu_operands_o = data_q;
  always_comb begin
    rf_req_idx_o = '0;
    for (int i = 0; i < OperandsPerInst; i++) rf_req_idx_o = k_q == KW'(i) ? srcs_q[i] : rf_req_idx_o;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= S_IDLE;
      k_q <= '0;
      srcs_q <= '0;
      data_q <= '0;
      eu_tag_o <= '0;
      eu_pc_o <= '0;
      eu_act_mask_o <= '0;
      eu_dst_o <= '0;
    end else if (accept) begin
      state_q <= S_REQ;
      k_q <= '0;
      srcs_q <= disp_operands_i;
      eu_tag_o <= disp_tag_i;
      eu_pc_o <= disp_pc_i;
      eu_act_mask_o <= disp_act_mask_i;
      eu_dst_o <= disp_dst_i;
    end else if (state_q == S_REQ && rf_req_ready_i) begin
      state_q <= S_WAIT;
    end else if (state_q == S_WAIT && rf_rsp_valid_i) begin
      for (int i = 0; i < OperandsPerInst; i++) if (k_q == KW'(i)) data_q[i] <= rf_rsp_data_i;
      state_q <= last ? S_ISSUE : S_REQ;
      k_q <= last ? k_q : k_q + 1'b1;
    end else if (state_q == S_ISSUE && eu_ready_i) begin
      state_q <= S_IDLE;
    end
`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (rst_i) eu_valid_o && !eu_ready_i |=>
    eu_valid_o && $stable({eu_tag_o, eu_pc_o, eu_act_mask_o, eu_dst_o, eu_operands_o}));
  assert property (@(posedge clk_i) disable iff (rst_i) rf_req_valid_o && !rf_req_ready_i |=>
    rf_req_valid_o && $stable(rf_req_idx_o));
  assert property (@(posedge clk_i) disable iff (rst_i) rf_rsp_valid_i |-> state_q == S_WAIT)
    else $warning("operand_collector: rf response outside WAIT ignored");
`endif
endmodule

// File: tb/tb_operand_collector.sv
// tb_operand_collector: directed and randomized checks of the operand collector against a register-file model
module tb_operand_collector;
  localparam int OPI = 2;
  localparam int RIW = 6;
  localparam int DW = 1024;
  logic clk_i = 0;
  logic rst_i = 1;
  logic opc_ready_o, disp_valid_i, rf_req_valid_o, rf_req_ready_i, rf_rsp_valid_i, eu_valid_o, eu_ready_i;
  logic [2:0] disp_tag_i, eu_tag_o;
  logic [31:0] disp_pc_i, disp_act_mask_i, eu_pc_o, eu_act_mask_o;
  logic [RIW-1:0] disp_dst_i, eu_dst_o, rf_req_idx_o;
  logic [OPI*RIW-1:0] disp_operands_i;
  logic [DW-1:0] rf_rsp_data_i;
  logic [OPI*DW-1:0] eu_operands_o;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] regs [64];
  logic [2:0] c_tag;
  logic [31:0] c_pc, c_mask;
  logic [RIW-1:0] c_dst;
  logic [RIW-1:0] c_src [OPI];
  int c0;

  operand_collector dut (
    .clk_i(clk_i), .rst_i(rst_i), .opc_ready_o(opc_ready_o),
    .disp_valid_i(disp_valid_i), .disp_tag_i(disp_tag_i), .disp_pc_i(disp_pc_i),
    .disp_act_mask_i(disp_act_mask_i), .disp_dst_i(disp_dst_i), .disp_operands_i(disp_operands_i),
    .rf_req_valid_o(rf_req_valid_o), .rf_req_ready_i(rf_req_ready_i), .rf_req_idx_o(rf_req_idx_o),
    .rf_rsp_valid_i(rf_rsp_valid_i), .rf_rsp_data_i(rf_rsp_data_i),
    .eu_valid_o(eu_valid_o), .eu_ready_i(eu_ready_i), .eu_tag_o(eu_tag_o), .eu_pc_o(eu_pc_o),
    .eu_act_mask_o(eu_act_mask_o), .eu_dst_o(eu_dst_o), .eu_operands_o(eu_operands_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic new_instr();
    c_tag = 3'($urandom);
    c_pc = $urandom;
    c_mask = $urandom;
    c_dst = RIW'($urandom);
    for (int i = 0; i < OPI; i++) c_src[i] = RIW'($urandom_range(63, 0));
  endtask

  task automatic drive_disp();
    disp_valid_i = 1;
    disp_tag_i = c_tag;
    disp_pc_i = c_pc;
    disp_act_mask_i = c_mask;
    disp_dst_i = c_dst;
    for (int i = 0; i < OPI; i++) disp_operands_i[i*RIW +: RIW] = c_src[i];
    c0 = cyc;
  endtask

  task automatic dispatch(input bit directed);
    int w = 0;
    while (!opc_ready_o && w < 50) begin
      @(negedge clk_i);
      w++;
    end
    check("opc_ready_before_dispatch", opc_ready_o, 1);
    if (!directed) new_instr();
    drive_disp();
    @(negedge clk_i);
    disp_valid_i = 0;
  endtask

  task automatic collect(input int rf_stall, input int rsp_lat);
    logic [RIW-1:0] idx;
    for (int i = 0; i < OPI; i++) begin
      check("rf_req_valid", rf_req_valid_o, 1);
      check("rf_req_idx", rf_req_idx_o, c_src[i]);
      idx = rf_req_idx_o;
      repeat (rf_stall) begin
        @(negedge clk_i);
        check("rf_req_valid_held", rf_req_valid_o, 1);
        check("rf_req_idx_stable", rf_req_idx_o, idx);
      end
      rf_req_ready_i = 1;
      @(negedge clk_i);
      rf_req_ready_i = 0;
      check("rf_req_dropped_in_wait", rf_req_valid_o, 0);
      repeat (rsp_lat - 1) @(negedge clk_i);
      rf_rsp_valid_i = 1;
      rf_rsp_data_i = regs[idx];
      @(negedge clk_i);
      rf_rsp_valid_i = 0;
      rf_rsp_data_i = rnd_data();
    end
  endtask

  task automatic check_fields();
    check("eu_tag", eu_tag_o, c_tag);
    check("eu_pc", eu_pc_o, c_pc);
    check("eu_act_mask", eu_act_mask_o, c_mask);
    check("eu_dst", eu_dst_o, c_dst);
    for (int k = 0; k < OPI; k++) check($sformatf("eu_operand%0d", k), eu_operands_o[k*DW +: DW], regs[c_src[k]]);
  endtask

  task automatic issue(input int eu_stall, input int exp_lat, input bit chain);
    check("eu_valid", eu_valid_o, 1);
    if (exp_lat > 0) check("dispatch_to_eu_latency", cyc - c0, exp_lat);
    for (int s = 0; s <= eu_stall; s++) begin
      check_fields();
      check("opc_ready_in_issue", opc_ready_o, 0);
      check("eu_valid_held", eu_valid_o, 1);
      if (s < eu_stall) @(negedge clk_i);
    end
    eu_ready_i = 1;
    #1;
`ifdef OPC_ISSUE_BYPASS_EN
    check("opc_ready_at_eu_handshake", opc_ready_o, 1);
`else
    check("opc_ready_at_eu_handshake", opc_ready_o, 0);
`endif
    if (chain) begin
      new_instr();
      drive_disp();
    end
    @(negedge clk_i);
    eu_ready_i = 0;
    disp_valid_i = 0;
    check("eu_valid_after_handshake", eu_valid_o, 0);
    check("opc_ready_after_handshake", opc_ready_o, !chain);
  endtask

  initial begin
    disp_valid_i = 0;
    disp_tag_i = 0;
    disp_pc_i = 0;
    disp_act_mask_i = 0;
    disp_dst_i = 0;
    disp_operands_i = 0;
    rf_req_ready_i = 0;
    rf_rsp_valid_i = 0;
    rf_rsp_data_i = 0;
    eu_ready_i = 0;
    for (int r = 0; r < 64; r++) regs[r] = rnd_data();
    repeat (3) @(negedge clk_i);
    check("reset_opc_ready", opc_ready_o, 1);
    check("reset_rf_req_valid", rf_req_valid_o, 0);
    check("reset_eu_valid", eu_valid_o, 0);
    check("reset_eu_tag", eu_tag_o, 0);
    check("reset_eu_operand0", eu_operands_o[DW-1:0], 0);
    check("reset_eu_operand1", eu_operands_o[2*DW-1:DW], 0);
    rst_i = 0;
    @(negedge clk_i);
    check("idle_opc_ready", opc_ready_o, 1);
    c_tag = 3;
    c_pc = 32'h40;
    c_mask = 32'hffff_ffff;
    c_dst = 9;
    c_src[0] = 5;
    c_src[1] = 7;
    dispatch(1);
    collect(0, 1);
    issue(0, 2 * OPI + 1, 0);
    dispatch(0);
    collect(4, 1);
    issue(0, -1, 0);
    dispatch(0);
    collect(0, 1);
    issue(6, 2 * OPI + 1, 0);
`ifdef OPC_ISSUE_BYPASS_EN
    dispatch(0);
    collect(0, 1);
    issue(2, 2 * OPI + 1, 1);
    collect(0, 1);
    issue(0, 2 * OPI + 1, 0);
`endif
    rf_rsp_valid_i = 1;
    rf_rsp_data_i = rnd_data();
    @(negedge clk_i);
    rf_rsp_valid_i = 0;
    check("spurious_rsp_opc_ready", opc_ready_o, 1);
    check("spurious_rsp_rf_req_valid", rf_req_valid_o, 0);
    check("spurious_rsp_eu_valid", eu_valid_o, 0);
    dispatch(0);
    rf_req_ready_i = 1;
    @(negedge clk_i);
    rf_req_ready_i = 0;
    #2 rst_i = 1;
    #1;
    check("midreset_opc_ready", opc_ready_o, 1);
    check("midreset_rf_req_valid", rf_req_valid_o, 0);
    check("midreset_eu_valid", eu_valid_o, 0);
    @(negedge clk_i);
    rst_i = 0;
    rf_rsp_valid_i = 1;
    rf_rsp_data_i = rnd_data();
    @(negedge clk_i);
    rf_rsp_valid_i = 0;
    check("late_rsp_opc_ready", opc_ready_o, 1);
    check("late_rsp_rf_req_valid", rf_req_valid_o, 0);
    check("late_rsp_eu_valid", eu_valid_o, 0);
    dispatch(0);
    collect(0, 1);
    issue(0, 2 * OPI + 1, 0);
    for (int n = 0; n < 8; n++) begin
      dispatch(0);
      collect($urandom_range(3, 0), $urandom_range(3, 1));
      issue($urandom_range(4, 0), -1, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_collector.md
Name: operand_collector

Overview:
- Single-entry operand collector; the receiving end of the dispatcher's issue interface (disp_valid/opc_ready handshake).
- Accepts one dispatched instruction and reads its source operands from the register file one at a time over a single read port.
- Presents the complete instruction plus operand data to the execution units.
- Sits between the dispatcher and the EUs. The EU completion tag path back to the dispatcher is not driven here.

Parameters:
- NumTags, 8, inflight tags; TagWidth = $clog2(NumTags)
- PcWidth, 32, program counter width
- WarpWidth, 32, threads per warp
- RegIdxWidth, 6, register index width
- OperandsPerInst, 2, source operands per instruction (>=1)
- RegWidth, 32, bits per thread register; operand data width = WarpWidth*RegWidth

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- opc_ready_o  out  1  may accept dispatched instruction
- disp_valid_i  in  1  dispatcher instruction valid
- disp_tag_i  in  TagWidth  instruction tag
- disp_pc_i  in  PcWidth  pc
- disp_act_mask_i  in  WarpWidth  active mask
- disp_dst_i  in  RegIdxWidth  destination register
- disp_operands_i  in  OperandsPerInst*RegIdxWidth  source registers
- rf_req_valid_o  out  1  register read request
- rf_req_ready_i  in  1  register file accepts request
- rf_req_idx_o  out  RegIdxWidth  register to read
- rf_rsp_valid_i  in  1  read data valid; in order, no backpressure
- rf_rsp_data_i  in  WarpWidth*RegWidth  read data
- eu_valid_o  out  1  collected instruction valid
- eu_ready_i  in  1  EU accepts
- eu_tag_o, eu_pc_o, eu_act_mask_o, eu_dst_o  out  as above  registered instruction fields
- eu_operands_o  out  OperandsPerInst*WarpWidth*RegWidth  operand data; index k = operand k

Behaviour:
- States: IDLE, REQ, WAIT, ISSUE. Reset enters IDLE.
- Reset values: opc_ready_o=1, rf_req_valid_o=0, eu_valid_o=0. All data registers and the counter are 0.
- IDLE:
  - opc_ready_o=1.
  - On disp_valid_i, capture all disp_* fields, set operand counter k=0, go to REQ.
- REQ:
  - rf_req_valid_o=1, rf_req_idx_o = captured operand k.
  - Hold valid and idx stable until rf_req_ready_i; on handshake go to WAIT.
- WAIT:
  - At most one request outstanding.
  - On rf_rsp_valid_i, store data into slot k. If k==OperandsPerInst-1 go to ISSUE, else k++ and go to REQ.
  - A response in the same cycle as the request handshake is illegal (minimum read latency 1).
- ISSUE:
  - eu_valid_o=1. All eu_* outputs come from registers and are stable until eu_ready_i.
  - On handshake go to IDLE.
- Counter width: max(1,$clog2(OperandsPerInst)). The counter never wraps past OperandsPerInst-1.
- Minimum latency, dispatch accept to eu_valid_o, with zero-wait RF (ready=1, response the next cycle): 2*OperandsPerInst+1 cycles.
- rf_rsp_valid_i outside WAIT: ignored by RTL; assertion error in simulation.
- disp_valid_i while opc_ready_o=0: ignored; the dispatcher holds it.
- Reset mid-operation: immediately IDLE, in-flight instruction dropped. A late RF response after reset is ignored.
- Assertions (non-synthesis):
  - eu_* outputs stable while eu_valid_o && !eu_ready_i.
  - rf_req_idx_o stable while rf_req_valid_o && !rf_req_ready_i.

Optional Feature:
- Macro OPC_ISSUE_BYPASS_EN.
- Defined:
  - opc_ready_o = IDLE || (ISSUE && eu_ready_i).
  - A dispatch accepted in the same cycle as the EU handshake captures the new instruction and goes directly to REQ with k=0. This enables back-to-back instructions without an idle bubble.
  - opc_ready_o then depends combinationally on eu_ready_i.
- Undefined:
  - opc_ready_o = IDLE only; one bubble cycle between instructions.

Decomposition:
- Shared compute-unit package holds tag_t, pc_t, act_mask_t, reg_idx_t, the per-operand data type, and a state enum (opc_state_e: IDLE, REQ, WAIT, ISSUE).
- No sub-module warranted. The operand data store is a simple indexed register array inside the module.

Test Plan:
- Basic: OperandsPerInst=2, dispatch tag=3, pc=0x40, srcs {5,7}; RF ready=1, response 1 cycle later with data A,B -> rf_req_idx_o 5 then 7; eu_valid_o 5 cycles after accept with tag 3, operands[0]=A, operands[1]=B.
- RF backpressure: rf_req_ready_i low 4 cycles -> rf_req_valid_o held, idx stable; operands still correct.
- EU backpressure: eu_ready_i low 6 cycles -> outputs stable, opc_ready_o=0. Without the macro, opc_ready_o=1 the cycle after the handshake. With the macro, a new dispatch is accepted in the handshake cycle.
- Spurious rf_rsp_valid_i in IDLE -> no state change; assertion fires.
- Reset asserted in WAIT -> next cycle opc_ready_o=1, eu_valid_o=0. A subsequent dispatch completes normally.
- OperandsPerInst=1 build: single request, eu_valid_o 3 cycles after accept.
